sobel_frame_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 Sobel datapath.
- Accepts a raster-order 8-bit grayscale pixel stream of a fixed WIDTHxHEIGHT frame and buffers two prior lines in internal line buffers.
- Assembles the 3x3 window p0..p8 and drives one internal sobel_operator instance.
- Emits the (WIDTH-2)x(HEIGHT-2) interior edge-magnitude stream over a valid/ready handshake, framed by start/busy/done control.

---
 rtl/sobel_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel edge detector: two line buffers, a sliding window,
// and a single-entry valid/ready output stage producing the interior magnitude stream.

module sobel_operator (
    input  logic [7:0] i_p0,
    input  logic [7:0] i_p1,
    input  logic [7:0] i_p2,
    input  logic [7:0] i_p3,
    input  logic [7:0] i_p5,
    input  logic [7:0] i_p6,
    input  logic [7:0] i_p7,
    input  logic [7:0] i_p8,
    output logic [7:0] o_mag
);
    logic signed [10:0] w_s0, w_s1, w_s2, w_s3, w_s5, w_s6, w_s7, w_s8;
    logic signed [10:0] w_gx, w_gy;
    logic        [10:0] w_ax, w_ay;
    logic        [11:0] w_sum;

    always_comb begin
        w_s0  = $signed({3'b000, i_p0});
        w_s1  = $signed({3'b000, i_p1});
        w_s2  = $signed({3'b000, i_p2});
        w_s3  = $signed({3'b000, i_p3});
        w_s5  = $signed({3'b000, i_p5});
        w_s6  = $signed({3'b000, i_p6});
        w_s7  = $signed({3'b000, i_p7});
        w_s8  = $signed({3'b000, i_p8});
        w_gx  = (w_s2 - w_s0) + (w_s5 - w_s3) + (w_s5 - w_s3) + (w_s8 - w_s6);
        w_gy  = (w_s0 - w_s6) + (w_s1 - w_s7) + (w_s1 - w_s7) + (w_s2 - w_s8);
        w_ax  = w_gx[10] ? 11'(-w_gx) : 11'(w_gx);
        w_ay  = w_gy[10] ? 11'(-w_gy) : 11'(w_gy);
        w_sum = {1'b0, w_ax} + {1'b0, w_ay};
        o_mag = (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];
    end
endmodule

module sobel_frame_ctrl #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int COL_W  = $clog2(WIDTH),
    parameter int ROW_W  = $clog2(HEIGHT)
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_pixel_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_pixel_o,
    output logic       out_last_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [7:0]       r_lba [WIDTH];
    logic [7:0]       r_lbb [WIDTH];
    // Two most recent columns of the window; the third column comes straight from the buffers/input.
    logic [7:0]       r_top0, r_top1, r_mid0, r_mid1, r_bot0, r_bot1;
    logic             r_out_valid;
    logic [7:0]       r_out_pixel;
    logic             r_out_last;

    logic       w_accept, w_fire, w_col_end, w_last_px, w_guard;
    logic [7:0] w_top, w_mid, w_mag;

    assign w_top     = r_lba[r_col];
    assign w_mid     = r_lbb[r_col];
    assign w_accept  = in_valid_i & in_ready_o;
    assign w_fire    = r_out_valid & out_ready_i;
    assign w_col_end = (r_col == COL_W'(WIDTH - 1));
    assign w_last_px = w_col_end & (r_row == ROW_W'(HEIGHT - 1));
    assign w_guard   = (r_row >= ROW_W'(2)) & (r_col >= COL_W'(2));

    sobel_operator u_sobel (
        .i_p0  (r_top0),
        .i_p1  (r_top1),
        .i_p2  (w_top),
        .i_p3  (r_mid0),
        .i_p5  (w_mid),
        .i_p6  (r_bot0),
        .i_p7  (r_bot1),
        .i_p8  (in_pixel_i),
        .o_mag (w_mag)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy_o     = 1'b1;
                in_ready_o = ~r_out_valid | out_ready_i;
                if (w_accept && w_last_px) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (!r_out_valid || out_ready_i) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start_i) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (w_last_px) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lba[r_col] <= w_mid;
            r_lbb[r_col] <= in_pixel_i;
            r_top0       <= r_top1;
            r_top1       <= w_top;
            r_mid0       <= r_mid1;
            r_mid1       <= w_mid;
            r_bot0       <= r_bot1;
            r_bot1       <= in_pixel_i;
        end
    end

    // A load takes priority over a fire so back-to-back outputs need no bubble.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept && w_guard) begin
            r_out_valid <= 1'b1;
            r_out_pixel <= w_mag;
            r_out_last  <= w_last_px;
        end else if (w_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_pixel_o = r_out_pixel;
    assign out_last_o  = r_out_last;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 5x4 frame with hand-computed magnitudes.

module tb_sobel_frame_ctrl;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NOUT = 6;
    localparam int NPIX = 20;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       start     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_pixel  = '0;
    logic       out_ready = 1'b1;
    logic       busy_o, done_o, in_ready_o, out_valid_o, out_last_o;
    logic [7:0] out_pixel_o;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .start_i     (start),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .in_pixel_i  (in_pixel),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .out_pixel_o (out_pixel_o),
        .out_last_o  (out_last_o)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] got_pix  [16];
    logic       got_last [16];
    int         n_out, n_acc, n_done, last_fire_cyc, done_cyc;
    bit         timed_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] pix(input int img, input int r, input int c);
        case (img)
            0:       return 8'h80;
            1:       return (c >= 3) ? 8'd100 : 8'd0;
            default: return (r >= 2) ? 8'd10 : 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] exp_out(input int img, input int i);
        case (img)
            0:       return 8'd0;
            1:       return ((i % 3) == 0) ? 8'd0 : 8'd255;
            default: return 8'd40;
        endcase
    endfunction

    task automatic run_frame(input int img, input bit stall_en, input bit mid_start, input int abort_at);
        int         cyc        = 0;
        int         stall_left = 0;
        bit         stall_done = 0;
        bit         mid_done   = 0;
        logic [7:0] held       = '0;
        n_out = 0; n_acc = 0; n_done = 0; last_fire_cyc = -100; done_cyc = -1; timed_out = 0;
        forever begin
            @(negedge clk);
            if (abort_at > 0 && n_acc == abort_at) begin
                in_valid = 1'b0;
                start    = 1'b0;
                reset_n  = 1'b0;
                #1;
                check("abort_busy", busy_o, 0);
                check("abort_done", done_o, 0);
                check("abort_in_ready", in_ready_o, 0);
                check("abort_out_valid", out_valid_o, 0);
                check("abort_out_pixel", out_pixel_o, 0);
                check("abort_out_last", out_last_o, 0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            start = (cyc == 0) || (mid_start && !mid_done && n_acc == 7);
            if (start && cyc > 0) mid_done = 1;
            if (stall_en && !stall_done && out_valid_o) begin
                stall_done = 1;
                stall_left = 10;
                held       = out_pixel_o;
            end
            out_ready = (stall_left == 0);
            in_valid  = (n_acc < NPIX);
            in_pixel  = pix(img, n_acc / W, n_acc % W);
            #1;
            if (cyc == 0) check("idle_in_ready", in_ready_o, 0);
            if (cyc == 1) check("run_busy", busy_o, 1);
            if (stall_left > 0) begin
                check("stall_in_ready", in_ready_o, 0);
                check("stall_valid", out_valid_o, 1);
                check("stall_pixel", out_pixel_o, held);
                stall_left--;
            end
            if (out_valid_o && out_ready) begin
                if (n_out < 16) begin
                    got_pix[n_out]  = out_pixel_o;
                    got_last[n_out] = out_last_o;
                end
                n_out++;
                if (out_last_o) last_fire_cyc = cyc;
            end
            if (in_valid && in_ready_o) n_acc++;
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            cyc++;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic verify(input int img);
        int d;
        d = done_cyc - last_fire_cyc;
        check($sformatf("img%0d_timeout", img), timed_out, 0);
        check($sformatf("img%0d_n_out", img), n_out, NOUT);
        check($sformatf("img%0d_n_acc", img), n_acc, NPIX);
        check($sformatf("img%0d_n_done", img), n_done, 1);
        check($sformatf("img%0d_done_latency", img), (d >= 1 && d <= 2), 1);
        for (int i = 0; i < NOUT; i++) begin
            check($sformatf("img%0d_pix%0d", img, i), got_pix[i], exp_out(img, i));
            check($sformatf("img%0d_last%0d", img, i), got_last[i], (i == NOUT - 1));
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_pixel", out_pixel_o, 0);
        check("rst_out_last", out_last_o, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_frame(0, 0, 0, 0); verify(0);
        run_frame(1, 0, 0, 0); verify(1);
        run_frame(2, 0, 0, 0); verify(2);
        run_frame(1, 1, 0, 0); verify(1);
        run_frame(1, 0, 1, 0); verify(1);
        run_frame(1, 0, 0, 12);
        run_frame(1, 0, 0, 0); verify(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
